// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: command encodings, register indices, bit positions, FSM states.
package cp0_pkg;

    localparam int unsigned XLEN = 32;

    // Command issued by the controller from the EXE stage
    typedef enum logic [1:0] {
        CP_NONE  = 2'd0,
        CP_STORE = 2'd1,
        CP_ERET  = 2'd2
    } cp_oper_e;

    // CP0 register indices (rd field)
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_BASE    = 5'd15;

    // Status / Cause bit positions
    localparam int unsigned STATUS_IE  = 0;
    localparam int unsigned STATUS_EXL = 1;
    localparam int unsigned CAUSE_IP2  = 10;
    localparam int unsigned CAUSE_IP7  = 15;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } cp0_state_e;

endpackage

// File: rtl/cp0_unit_sync2.sv
// Two-flop synchronizer for an asynchronous level input.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the input through two flops to settle metastability
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 responder: Status/Cause/EPC/Base, external interrupt, ERET/interrupt redirect.
// Optional Count/Compare timer (IP7) is built when CP0_TIMER_EN is defined.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_RST = 32'h0000_0008
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      cp_oper,
    input  logic            cp_en,
    input  logic            valid_exe,
    input  logic [XLEN-1:0] pc_exe,
    input  logic [4:0]      addr_r,
    output logic [XLEN-1:0] data_r,
    input  logic [4:0]      addr_w,
    input  logic [XLEN-1:0] data_w,
    input  logic            ext_int,
    output logic            jump_en,
    output logic [XLEN-1:0] jump_addr,
    output logic            flush,
    output logic            int_pending
);

    cp0_state_e      state_q, state_d;
    logic            ie_q, ie_d;
    logic            exl_q, exl_d;
    logic            ip2_q, ip2_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] base_q, base_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            jump_en_q, jump_en_d;
    logic            flush_q, flush_d;
    logic            int_prev_q;
    logic            int_sync;
    logic            int_rise;
    logic            ip7;
    logic            commit;
    logic            int_req;
    logic [XLEN-1:0] cause_rd;
    cp_oper_e        oper;

`ifdef CP0_TIMER_EN
    logic [XLEN-1:0] count_q, count_d;
    logic [XLEN-1:0] compare_q, compare_d;
    logic            ip7_q, ip7_d;
    assign ip7 = ip7_q;
`else
    assign ip7 = 1'b0;
`endif

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d_i (ext_int),
        .q_o (int_sync)
    );

    assign oper     = cp_oper_e'(cp_oper);
    assign int_rise = int_sync & ~int_prev_q;
    assign commit   = cp_en & valid_exe & (state_q == ST_IDLE);
    assign int_req  = ie_q & ~exl_q & (ip2_q | ip7);

    // Next-state: interrupt accept beats ERET/STORE; REDIRECT lasts one cycle
    always_comb begin
        state_d   = state_q;
        ie_d      = ie_q;
        exl_d     = exl_q;
        ip2_d     = ip2_q;
        epc_d     = epc_q;
        base_d    = base_q;
        target_d  = target_q;
        jump_en_d = 1'b0;
        flush_d   = 1'b0;
`ifdef CP0_TIMER_EN
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        ip7_d     = ip7_q | (count_q == compare_q);
`endif
        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    if (int_req) begin
                        epc_d     = pc_exe;
                        exl_d     = 1'b1;
                        ip2_d     = 1'b0;
`ifdef CP0_TIMER_EN
                        ip7_d     = 1'b0;
`endif
                        target_d  = base_q;
                        state_d   = ST_REDIRECT;
                        jump_en_d = 1'b1;
                        flush_d   = 1'b1;
                    end else if (oper == CP_ERET) begin
                        exl_d     = 1'b0;
                        target_d  = epc_q;
                        state_d   = ST_REDIRECT;
                        jump_en_d = 1'b1;
                        flush_d   = 1'b1;
                    end else if (oper == CP_STORE) begin
                        case (addr_w)
                            REG_STATUS: begin
                                ie_d  = data_w[STATUS_IE];
                                exl_d = data_w[STATUS_EXL];
                            end
                            REG_CAUSE: ip2_d  = data_w[CAUSE_IP2];
                            REG_EPC:   epc_d  = data_w;
                            REG_BASE:  base_d = data_w;
`ifdef CP0_TIMER_EN
                            REG_COMPARE: begin
                                compare_d = data_w;
                                ip7_d     = 1'b0;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        // A fresh interrupt edge is never lost, even in the cycle IP2 is cleared
        if (int_rise) begin
            ip2_d = 1'b1;
        end
    end

    // State and register update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ie_q       <= 1'b0;
            exl_q      <= 1'b0;
            ip2_q      <= 1'b0;
            epc_q      <= '0;
            base_q     <= HANDLER_RST;
            target_q   <= '0;
            jump_en_q  <= 1'b0;
            flush_q    <= 1'b0;
            int_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ie_q       <= ie_d;
            exl_q      <= exl_d;
            ip2_q      <= ip2_d;
            epc_q      <= epc_d;
            base_q     <= base_d;
            target_q   <= target_d;
            jump_en_q  <= jump_en_d;
            flush_q    <= flush_d;
            int_prev_q <= int_sync;
        end
    end

`ifdef CP0_TIMER_EN
    // Timer registers; Compare resets to all-ones so IP7 stays clear out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            compare_q <= '1;
            ip7_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ip7_q     <= ip7_d;
        end
    end
`endif

    // Cause read view
    always_comb begin
        cause_rd            = '0;
        cause_rd[CAUSE_IP2] = ip2_q;
        cause_rd[CAUSE_IP7] = ip7;
    end

    // MFC0 read mux, no bypass of a same-cycle store
    always_comb begin
        data_r = '0;
        case (addr_r)
            REG_STATUS: data_r = {30'd0, exl_q, ie_q};
            REG_CAUSE:  data_r = cause_rd;
            REG_EPC:    data_r = epc_q;
            REG_BASE:   data_r = base_q;
`ifdef CP0_TIMER_EN
            REG_COUNT:   data_r = count_q;
            REG_COMPARE: data_r = compare_q;
`endif
            default: data_r = '0;
        endcase
    end

    assign jump_en     = jump_en_q;
    assign flush       = flush_q;
    assign jump_addr   = target_q;
    assign int_pending = ip2_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit: vector table plus interrupt/ERET/reset sequences.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cp_oper;
    logic        cp_en;
    logic        valid_exe;
    logic [31:0] pc_exe;
    logic [4:0]  addr_r;
    logic [31:0] data_r;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic        ext_int;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        flush;
    logic        int_pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic        en;
        logic        vld;
        logic [31:0] pc;
        logic [4:0]  aw;
        logic [31:0] dw;
        logic [4:0]  ar;
        logic [31:0] exp_dr;
        logic        exp_je;
        logic        exp_fl;
        logic [31:0] exp_ja;
    } vec_t;

    vec_t vecs[18];

    cp0_unit #(.HANDLER_RST(32'h0000_0008)) dut (
        .clk         (clk),
        .rst         (rst),
        .cp_oper     (cp_oper),
        .cp_en       (cp_en),
        .valid_exe   (valid_exe),
        .pc_exe      (pc_exe),
        .addr_r      (addr_r),
        .data_r      (data_r),
        .addr_w      (addr_w),
        .data_w      (data_w),
        .ext_int     (ext_int),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .flush       (flush),
        .int_pending (int_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        addr_r = a;
        #1;
        chk(name, data_r, exp);
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic en, input logic vld,
                                input logic [31:0] pc, input logic [4:0] aw,
                                input logic [31:0] dw, input logic [4:0] ar,
                                input logic [31:0] edr, input logic eje, input logic efl,
                                input logic [31:0] eja);
        vec_t v;
        v.op = op; v.en = en; v.vld = vld; v.pc = pc; v.aw = aw; v.dw = dw; v.ar = ar;
        v.exp_dr = edr; v.exp_je = eje; v.exp_fl = efl; v.exp_ja = eja;
        return v;
    endfunction

    initial begin
        bit          found;
        logic [31:0] cnt;

        // op: 0 NONE, 1 STORE, 2 ERET; outputs are checked before the edge that consumes inputs
        vecs[0]  = mk(2'd0, 1'b0, 1'b1, 32'h0, 5'd0,  32'h0,      5'd12, 32'h0,      1'b0, 1'b0, 32'h0);
        vecs[1]  = mk(2'd0, 1'b0, 1'b1, 32'h0, 5'd0,  32'h0,      5'd13, 32'h0,      1'b0, 1'b0, 32'h0);
        vecs[2]  = mk(2'd0, 1'b0, 1'b1, 32'h0, 5'd0,  32'h0,      5'd14, 32'h0,      1'b0, 1'b0, 32'h0);
        vecs[3]  = mk(2'd0, 1'b0, 1'b1, 32'h0, 5'd0,  32'h0,      5'd15, 32'h8,      1'b0, 1'b0, 32'h0);
        vecs[4]  = mk(2'd1, 1'b1, 1'b1, 32'h0, 5'd12, 32'h3,      5'd12, 32'h0,      1'b0, 1'b0, 32'h0);
        vecs[5]  = mk(2'd0, 1'b0, 1'b1, 32'h0, 5'd0,  32'h0,      5'd12, 32'h3,      1'b0, 1'b0, 32'h0);
        vecs[6]  = mk(2'd1, 1'b0, 1'b1, 32'h0, 5'd12, 32'h0,      5'd12, 32'h3,      1'b0, 1'b0, 32'h0);
        vecs[7]  = mk(2'd0, 1'b0, 1'b1, 32'h0, 5'd0,  32'h0,      5'd12, 32'h3,      1'b0, 1'b0, 32'h0);
        vecs[8]  = mk(2'd1, 1'b1, 1'b0, 32'h0, 5'd12, 32'h0,      5'd12, 32'h3,      1'b0, 1'b0, 32'h0);
        vecs[9]  = mk(2'd0, 1'b0, 1'b1, 32'h0, 5'd0,  32'h0,      5'd12, 32'h3,      1'b0, 1'b0, 32'h0);
        vecs[10] = mk(2'd1, 1'b1, 1'b1, 32'h0, 5'd14, 32'h1234,   5'd14, 32'h0,      1'b0, 1'b0, 32'h0);
        vecs[11] = mk(2'd0, 1'b0, 1'b1, 32'h0, 5'd0,  32'h0,      5'd14, 32'h1234,   1'b0, 1'b0, 32'h0);
        vecs[12] = mk(2'd1, 1'b1, 1'b1, 32'h0, 5'd20, 32'hFFFF,   5'd20, 32'h0,      1'b0, 1'b0, 32'h0);
        vecs[13] = mk(2'd0, 1'b0, 1'b1, 32'h0, 5'd0,  32'h0,      5'd20, 32'h0,      1'b0, 1'b0, 32'h0);
        vecs[14] = mk(2'd2, 1'b1, 1'b1, 32'h0, 5'd0,  32'h0,      5'd12, 32'h3,      1'b0, 1'b0, 32'h0);
        vecs[15] = mk(2'd2, 1'b1, 1'b1, 32'h0, 5'd0,  32'h0,      5'd12, 32'h1,      1'b1, 1'b1, 32'h1234);
        vecs[16] = mk(2'd0, 1'b0, 1'b1, 32'h0, 5'd0,  32'h0,      5'd12, 32'h1,      1'b0, 1'b0, 32'h1234);
        vecs[17] = mk(2'd0, 1'b0, 1'b1, 32'h0, 5'd0,  32'h0,      5'd14, 32'h1234,   1'b0, 1'b0, 32'h1234);

        rst = 1'b0; cp_oper = 2'd0; cp_en = 1'b0; valid_exe = 1'b0; pc_exe = '0;
        addr_r = '0; addr_w = '0; data_w = '0; ext_int = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            cp_oper = vecs[i].op; cp_en = vecs[i].en; valid_exe = vecs[i].vld;
            pc_exe = vecs[i].pc; addr_w = vecs[i].aw; data_w = vecs[i].dw; addr_r = vecs[i].ar;
            #1;
            chk($sformatf("vec%0d data_r", i), data_r, vecs[i].exp_dr);
            chk($sformatf("vec%0d jump_en", i), 32'(jump_en), 32'(vecs[i].exp_je));
            chk($sformatf("vec%0d flush", i), 32'(flush), 32'(vecs[i].exp_fl));
            chk($sformatf("vec%0d jump_addr", i), jump_addr, vecs[i].exp_ja);
            @(posedge clk);
            #1;
        end

        // Interrupt latency: IE=1, EXL=0, pulse ext_int before edge k
        cp_oper = 2'd0; cp_en = 1'b1; valid_exe = 1'b1; pc_exe = 32'h40; ext_int = 1'b1;
        tick();                                   // edge k
        ext_int = 1'b0;
        chk("irq_k_pending", 32'(int_pending), 32'h0);
        tick();                                   // k+1
        chk("irq_k1_pending", 32'(int_pending), 32'h0);
        tick();                                   // k+2: IP2 set
        chk("irq_k2_pending", 32'(int_pending), 32'h1);
        chk("irq_k2_jump", 32'(jump_en), 32'h0);
        tick();                                   // k+3: accepted
        chk("irq_jump_en", 32'(jump_en), 32'h1);
        chk("irq_flush", 32'(flush), 32'h1);
        chk("irq_jump_addr", jump_addr, 32'h8);
        chk("irq_ip2_clear", 32'(int_pending), 32'h0);
        rd("irq_epc", 5'd14, 32'h40);
        rd("irq_status", 5'd12, 32'h3);
        tick();
        chk("irq_jump_one_cycle", 32'(jump_en), 32'h0);
        chk("irq_flush_one_cycle", 32'(flush), 32'h0);

        // Interrupt while EXL=1 stays pending until ERET plus one commit
        pc_exe = 32'h80; ext_int = 1'b1;
        tick();
        ext_int = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("exl_hold%0d", i), 32'(jump_en), 32'h0);
        end
        chk("exl_pending", 32'(int_pending), 32'h1);
        cp_oper = 2'd2;
        tick();
        cp_oper = 2'd0;
        chk("eret_jump_en", 32'(jump_en), 32'h1);
        chk("eret_jump_addr", jump_addr, 32'h40);
        rd("eret_status", 5'd12, 32'h1);
        tick();
        chk("eret_one_cycle", 32'(jump_en), 32'h0);
        tick();
        chk("late_irq_jump_en", 32'(jump_en), 32'h1);
        chk("late_irq_jump_addr", jump_addr, 32'h8);
        chk("late_irq_ip2_clear", 32'(int_pending), 32'h0);
        rd("late_irq_epc", 5'd14, 32'h80);
        tick();
        chk("late_irq_one_cycle", 32'(jump_en), 32'h0);

        // Stall blocks acceptance; interrupt beats a same-cycle MTC0 EPC
        cp_oper = 2'd2;
        tick();
        chk("eret2_jump_addr", jump_addr, 32'h80);
        cp_oper = 2'd0; cp_en = 1'b0;
        tick();
        ext_int = 1'b1;
        tick();
        ext_int = 1'b0;
        repeat (4) tick();
        chk("stall_pending", 32'(int_pending), 32'h1);
        chk("stall_no_jump", 32'(jump_en), 32'h0);
        cp_oper = 2'd1; addr_w = 5'd14; data_w = 32'hFF; cp_en = 1'b1; pc_exe = 32'hC0;
        tick();
        cp_oper = 2'd0; cp_en = 1'b0;
        chk("prio_jump_en", 32'(jump_en), 32'h1);
        chk("prio_jump_addr", jump_addr, 32'h8);
        rd("prio_epc", 5'd14, 32'hC0);
        tick();
        chk("prio_one_cycle", 32'(jump_en), 32'h0);

        // Asynchronous reset in the middle of a redirect
        cp_oper = 2'd2; cp_en = 1'b1;
        tick();
        cp_oper = 2'd0; cp_en = 1'b0;
        chk("rst_pre_jump_en", 32'(jump_en), 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("rst_async_jump_en", 32'(jump_en), 32'h0);
        chk("rst_async_flush", 32'(flush), 32'h0);
        chk("rst_async_jump_addr", jump_addr, 32'h0);
        rd("rst_status", 5'd12, 32'h0);
        rd("rst_base", 5'd15, 32'h8);
        #1 rst = 1'b1;
        tick();
        chk("rst_release_jump_en", 32'(jump_en), 32'h0);
        rd("rst_release_epc", 5'd14, 32'h0);

`ifdef CP0_TIMER_EN
        // Timer: Compare = Count + 5 sets IP7, which holds until Compare is rewritten
        addr_r = 5'd9;
        #1;
        cnt = data_r;
        cp_oper = 2'd1; addr_w = 5'd11; data_w = cnt + 32'd5; cp_en = 1'b1; valid_exe = 1'b1;
        tick();
        cp_oper = 2'd0; cp_en = 1'b0; addr_r = 5'd13;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            found = data_r[15];
        end
        chk("timer_ip7_set", 32'(found), 32'h1);
        repeat (3) tick();
        chk("timer_ip7_hold", 32'(data_r[15]), 32'h1);
        cp_oper = 2'd1; addr_w = 5'd11; data_w = 32'h0; cp_en = 1'b1;
        tick();
        cp_oper = 2'd0; cp_en = 1'b0;
        chk("timer_ip7_clear", 32'(data_r[15]), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
